// File: rtl/apb_pkg.sv
// Shared APB definitions: state encodings, default bus widths and strobe width.
// Used by the requester bridge, the memory slave and their benches.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_DATA_SIZE = 32;
  localparam int APB_ADDR_SIZE = 6;
  localparam int APB_STRB_SIZE = APB_DATA_SIZE / 8;

  function automatic int apb_strb_width(input int data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/apb_mst_timeout.sv
// Saturating ACCESS wait-state counter; o_expired flags TIMEOUT low-PREADY cycles.
// TIMEOUT of 0 disables expiry entirely.
module apb_mst_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // Keep at least one bit so TIMEOUT=0 still elaborates cleanly.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/apb_mst_bridge.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and
// one held response; a wait-state timeout aborts transfers to a hung slave.
module apb_mst_bridge
  import apb_pkg::*;
#(
  parameter int DATA_SIZE = APB_DATA_SIZE,
  parameter int ADDR_SIZE = APB_ADDR_SIZE,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_SIZE-1:0]   cmd_addr,
  input  logic [DATA_SIZE-1:0]   cmd_wdata,
  input  logic [DATA_SIZE/8-1:0] cmd_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTROBE,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  apb_state_e r_state, w_next;

  logic                   r_pwrite;
  logic [ADDR_SIZE-1:0]   r_paddr;
  logic [DATA_SIZE-1:0]   r_pwdata;
  logic [DATA_SIZE/8-1:0] r_pstrobe;
  logic                   r_rsp_valid;
  logic [DATA_SIZE-1:0]   r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_rsp_timeout;

  logic w_accept;
  logic w_done;
  logic w_abort;
  logic w_expired;

  assign cmd_ready = (r_state == IDLE) && !r_rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;
  // PREADY on the expiry edge wins over the timeout.
  assign w_done    = (r_state == ACCESS) && PREADY;
  assign w_abort   = (r_state == ACCESS) && !PREADY && w_expired;

  apb_mst_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_clr     (r_state == SETUP),
    .i_en      ((r_state == ACCESS) && !PREADY),
    .o_expired (w_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reads keep the previous PWDATA so the data bus does not toggle needlessly.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrobe <= '0;
    end else if (w_accept) begin
      r_pwrite  <= cmd_write;
      r_paddr   <= cmd_addr;
      r_pstrobe <= cmd_write ? cmd_strb : '0;
      if (cmd_write) begin
        r_pwdata <= cmd_wdata;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
      r_rsp_err     <= PSLVERR;
      r_rsp_timeout <= 1'b0;
    end else if (w_abort) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign PSEL        = (r_state != IDLE);
  assign PENABLE     = (r_state == ACCESS);
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PSTROBE     = r_pstrobe;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/apb_mst_bridge.md
# apb_mst_bridge

APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command. It is the initiator counterpart to `apb_slv_memory_reg` and drives it directly. It replaces hand-sequenced PSEL/PENABLE stimulus with a synthesizable master, so firmware-side logic and benches share one transfer engine. One transfer is outstanding at a time; a wait-state timeout guards against a hung slave.

## Interface
Parameters:
- DATA_SIZE, 32, PWDATA/PRDATA width; multiple of 8
- ADDR_SIZE, 6, PADDR width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports. One clock; reset is asynchronous, active-low, on PRESETn.
- PCLK  in  1  clock; all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_SIZE  target address
- cmd_wdata  in  DATA_SIZE  write data
- cmd_strb  in  DATA_SIZE/8  byte strobes; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and for aborted transfers
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_SIZE
- PWDATA  out  DATA_SIZE
- PSTROBE  out  DATA_SIZE/8
- PRDATA  in  DATA_SIZE
- PREADY, PSLVERR  in  1 each

## Operation
- FSM states:
  - IDLE (2'b00)
  - SETUP (2'b01)
  - ACCESS (2'b10)
- cmd_ready = (state==IDLE) && !rsp_valid. The block is combinational from registered state only.
- IDLE, on cmd accept: latch addr/write/wdata/strb into the APB output registers and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always advances to ACCESS after one cycle.
- ACCESS: PSEL=1, PENABLE=1. All APB outputs are held stable.
- ACCESS, PREADY high at a rising edge:
  - Capture PRDATA on reads (0 on writes) into rsp_rdata.
  - rsp_err = PSLVERR, rsp_timeout = 0.
  - Set rsp_valid; go to IDLE, dropping PSEL/PENABLE.
- ACCESS, PREADY low: increment the wait counter.
- Timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT with PREADY still low:
  - Go to IDLE and set rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY high on that same edge wins: normal completion, no timeout.
- For reads, PWDATA holds its last value and PSTROBE is driven 0. For writes, PSTROBE = cmd_strb.
- PSLVERR is sampled only when PSEL && PENABLE && PREADY.
- rsp_valid holds, with rsp_* stable, until rsp_ready. It clears on the rsp_ready edge.
- rsp_ready asserted while rsp_valid is low has no effect.

## Timing
- Reset: state IDLE, PSEL=PENABLE=PWRITE=0, PADDR/PWDATA/PSTROBE=0, rsp_valid=0, rsp_rdata=0, rsp_err=rsp_timeout=0, counter 0. cmd_ready=1 out of reset.
- Reset asserted mid-transfer: PSEL/PENABLE fall immediately (asynchronous). No response is produced for the abandoned command.
- Zero-wait slave:
  - Accept at edge 0; SETUP cycle 0–1; ACCESS cycle 1–2.
  - rsp_valid high after edge 2.
  - With rsp_ready tied high, cmd_ready returns after edge 3. Minimum issue interval is 3 cycles per transfer.
- N wait states add N cycles to the ACCESS phase.
- A timeout produces rsp_valid TIMEOUT+1 cycles after ACCESS entry.
- The counter is width $clog2(TIMEOUT+1) and saturates. It clears on SETUP→ACCESS entry.

## Structure
- Package apb_pkg holds:
  - State encodings IDLE/SETUP/ACCESS.
  - Default DATA_SIZE/ADDR_SIZE.
  - The strobe-width constant DATA_SIZE/8.
  - This package is shared with the slave and its benches.
- Sub-module apb_mst_timeout: wait counter with clear/enable inputs and an expired output, parameterized by TIMEOUT.

## Test plan
- Write addr 0x05, wdata 0x55555555, strb 0xF against the memory slave: PSEL 1 for 2 cycles, PENABLE 1 for the second, PSTROBE=0xF, rsp_valid after edge 2, rsp_err=0.
- Read back addr 0x05: rsp_rdata=0x55555555. PSTROBE=0 throughout and PWRITE=0.
- Slave with 3 wait states: ACCESS lasts 4 cycles with PADDR/PWDATA stable; response at edge 5 after accept.
- PREADY stuck low, TIMEOUT=16:
  - Abort 17 cycles after ACCESS entry with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Next command proceeds normally.
- PSLVERR=1 with PREADY: rsp_err=1, rsp_timeout=0. Holding rsp_ready low for 5 cycles keeps rsp_* stable and cmd_ready=0.
- PRESETn pulsed low during ACCESS: PSEL/PENABLE drop without waiting for PCLK, rsp_valid stays 0, cmd_ready=1 after release.
